router_link_stage: RTL and testbench

//  Registered hop between one router outqueue port (N/S/E/W) and the facing mailbox of the

---
 rtl/router_link_stage.sv | 92 +++++++++
 tb/tb_router_link_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_link_stage.sv
// Registered two-entry skid hop from a router outqueue port to the neighbouring mailbox.
// Off-grid destinations (and everything on a disabled edge link) are consumed and counted.
module router_link_stage #(
  parameter int unsigned MSG_WIDTH       = 48,
  parameter int unsigned CORDINATE_WIDTH = 4,
  parameter int unsigned GRID_ROWS       = 4,
  parameter int unsigned GRID_COLS       = 4,
  parameter bit          LINK_EN         = 1'b1,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MSG_WIDTH-1:0] in_value,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [MSG_WIDTH-1:0] out_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] fwd_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  logic [MSG_WIDTH-1:0]       head_q, head_d;
  logic [MSG_WIDTH-1:0]       tail_q, tail_d;
  logic [1:0]                 count_q, count_d;
  logic [CNT_WIDTH-1:0]       fwd_q, fwd_d;
  logic [CNT_WIDTH-1:0]       drop_q, drop_d;
  logic [CORDINATE_WIDTH-1:0] dest_row, dest_col;
  logic                       accept, pop, off_grid, drop, keep;

  // Handshake outputs come straight from flops so no comb path crosses the tile edge.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_value = head_q;
  assign fwd_count  = fwd_q;
  assign drop_count = drop_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  assign dest_row = in_value[MSG_WIDTH-1 -: CORDINATE_WIDTH];
  assign dest_col = in_value[MSG_WIDTH-1-CORDINATE_WIDTH -: CORDINATE_WIDTH];

  // Unsigned compare: wrapped -1 / broadcast codes land above the grid and are dropped.
  assign off_grid = (32'(dest_row) >= GRID_ROWS) || (32'(dest_col) >= GRID_COLS);
  assign drop     = !LINK_EN || off_grid;
  assign keep     = accept & ~drop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop && count_q == 2'd2) begin
      head_d = tail_q;
    end
    if (keep) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
        head_d = in_value;
      end else begin
        tail_d = in_value;
      end
    end
  end

  always_comb begin
    count_d = count_q + 2'(keep) - 2'(pop);
    fwd_d   = fwd_q;
    drop_d  = drop_q;
    if (pop && fwd_q != '1) begin
      fwd_d = fwd_q + 1'b1;
    end
    if (accept && drop && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_router_link_stage.sv
// Randomised bench for router_link_stage: queue-based reference model, one task per scenario.
// A second instance with LINK_EN=0 and narrow counters covers the edge port and saturation.
module tb_router_link_stage;

  localparam int unsigned MW = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [MW-1:0] in_value = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] out_value;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    fwd_count, drop_count;

  logic [MW-1:0] e_in_value = '0;
  logic          e_in_valid = 1'b0;
  logic          e_in_ready;
  logic [MW-1:0] e_out_value;
  logic          e_out_valid;
  logic          e_out_ready = 1'b1;
  logic [2:0]    e_fwd_count, e_drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents plus saturating counters.
  logic [MW-1:0] exp_q[$];
  int fwd_exp = 0;
  int drop_exp = 0;
  int e_drop_exp = 0;

  always #5 clk = ~clk;

  router_link_stage #(
    .MSG_WIDTH(MW), .CORDINATE_WIDTH(4), .GRID_ROWS(4), .GRID_COLS(4),
    .LINK_EN(1'b1), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

  router_link_stage #(
    .MSG_WIDTH(MW), .CORDINATE_WIDTH(4), .GRID_ROWS(4), .GRID_COLS(4),
    .LINK_EN(1'b0), .CNT_WIDTH(3)
  ) dut_edge (
    .clk(clk), .reset(reset),
    .in_value(e_in_value), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .out_value(e_out_value), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .fwd_count(e_fwd_count), .drop_count(e_drop_count)
  );

  function automatic logic [MW-1:0] mk_msg(input logic [3:0] r, input logic [3:0] c);
    logic [63:0] p;
    p = {$urandom(), $urandom()};
    return {r, c, p[39:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fwd_exp = 0;
    drop_exp = 0;
    e_drop_exp = 0;
  endtask

  // Advance the model by one clock using the inputs as they stand, then step to edge + 1.
  task automatic tick();
    logic [3:0] r, c;
    bit acc, pop;
    acc = in_valid && (exp_q.size() < 2);
    pop = (exp_q.size() != 0) && out_ready;
    r = in_value[47:44];
    c = in_value[43:40];
    if (pop) begin
      void'(exp_q.pop_front());
      if (fwd_exp < 255) fwd_exp++;
    end
    if (acc) begin
      if (r < 4 && c < 4) exp_q.push_back(in_value);
      else if (drop_exp < 255) drop_exp++;
    end
    if (e_in_valid && e_drop_exp < 7) e_drop_exp++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
    checks++; if (out_value !== '0) begin errors++; $display("FAIL reset_out_value: got %0h want 0", out_value); end
    checks++; if (fwd_count !== 8'd0) begin errors++; $display("FAIL reset_fwd: got %0d want 0", fwd_count); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    checks++; if (e_in_ready !== 1'b1) begin errors++; $display("FAIL reset_edge_ready: got %0h want 1", e_in_ready); end
    checks++; if (e_drop_count !== 3'd0) begin errors++; $display("FAIL reset_edge_drop: got %0d want 0", e_drop_count); end
  endtask

  task automatic test_single();
    logic [MW-1:0] m;
    m = mk_msg(4'd1, 4'd2);
    out_ready = 1'b1;
    in_value = m;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0h want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h want 1", out_valid); end
    checks++; if (out_value !== m) begin errors++; $display("FAIL single_value: got %0h want %0h", out_value, m); end
    tick();
    checks++; if (fwd_count !== 8'd1) begin errors++; $display("FAIL single_fwd: got %0d want 1", fwd_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0h want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] seq [3];
    int idx;
    bit acc;
    for (int i = 0; i < 3; i++) seq[i] = mk_msg(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    out_ready = 1'b0;
    in_value = seq[0];
    in_valid = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %0h want 1", in_ready); end
    in_value = seq[1];
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0h want 0", in_ready); end
    in_value = seq[2];
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_held: got %0h want 0", in_ready); end
    checks++; if (out_value !== seq[0]) begin errors++; $display("FAIL bp_head: got %0h want %0h", out_value, seq[0]); end
    out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
      if (out_valid && out_ready) begin
        checks++;
        if (out_value !== seq[idx]) begin
          errors++; $display("FAIL bp_order%0d: got %0h want %0h", idx, out_value, seq[idx]);
        end
        idx++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", idx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0h want 1", in_ready); end
    checks++; if (fwd_count !== 8'd4) begin errors++; $display("FAIL bp_fwd: got %0d want 4", fwd_count); end
  endtask

  task automatic test_offgrid();
    out_ready = 1'b1;
    in_value = mk_msg(4'hF, 4'($urandom_range(0, 3)));
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL off_ready: got %0h want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL off_row_valid: got %0h want 0", out_valid); end
    in_value = mk_msg(4'($urandom_range(0, 3)), 4'd4);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL off_col_valid: got %0h want 0", out_valid); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL off_drop: got %0d want 2", drop_count); end
  endtask

  task automatic test_link_disabled();
    e_in_value = mk_msg(4'd0, 4'd0);
    e_in_valid = 1'b1;
    checks++; if (e_in_ready !== 1'b1) begin errors++; $display("FAIL edge_ready: got %0h want 1", e_in_ready); end
    tick();
    e_in_valid = 1'b0;
    checks++; if (e_out_valid !== 1'b0) begin errors++; $display("FAIL edge_valid: got %0h want 0", e_out_valid); end
    checks++; if (e_drop_count !== 3'd1) begin errors++; $display("FAIL edge_drop: got %0d want 1", e_drop_count); end
    e_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e_in_value = mk_msg(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      tick();
    end
    e_in_valid = 1'b0;
    checks++; if (e_drop_count !== 3'd7) begin errors++; $display("FAIL edge_drop_sat: got %0d want 7", e_drop_count); end
    checks++; if (e_drop_count !== 3'(e_drop_exp)) begin errors++; $display("FAIL edge_drop_model: got %0d want %0d", e_drop_count, e_drop_exp); end
    checks++; if (e_fwd_count !== 3'd0 || e_out_value !== '0) begin
      errors++; $display("FAIL edge_idle: got fwd=%0d value=%0h want 0/0", e_fwd_count, e_out_value);
    end
  endtask

  // Random stream against the model; in_valid is held until accepted.
  task automatic stream(input int n, input int off_pct, input bit toggle);
    int sent, cyc;
    bit acc;
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    while ((sent < n || exp_q.size() != 0) && cyc < 4000) begin
      if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
        if (int'($urandom_range(0, 99)) < off_pct) begin
          if ($urandom_range(0, 1) == 0) in_value = mk_msg(4'($urandom_range(4, 15)), 4'($urandom_range(0, 3)));
          else in_value = mk_msg(4'($urandom_range(0, 3)), 4'($urandom_range(4, 15)));
        end else begin
          in_value = mk_msg(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end
        in_valid = 1'b1;
      end
      out_ready = toggle ? !out_ready : 1'($urandom_range(0, 1));
      checks++; if (in_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL stream_ready@%0d: got %0h want %0h", cyc, in_ready, exp_q.size() < 2); end
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL stream_valid@%0d: got %0h want %0h", cyc, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if (out_value !== exp_q[0]) begin errors++; $display("FAIL stream_value@%0d: got %0h want %0h", cyc, out_value, exp_q[0]); end
      end
      checks++; if (fwd_count !== 8'(fwd_exp)) begin errors++; $display("FAIL stream_fwd@%0d: got %0d want %0d", cyc, fwd_count, fwd_exp); end
      checks++; if (drop_count !== 8'(drop_exp)) begin errors++; $display("FAIL stream_drop@%0d: got %0d want %0d", cyc, drop_count, drop_exp); end
      acc = in_valid && (exp_q.size() < 2);
      if (acc) sent++;
      tick();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc >= 4000) begin errors++; $display("FAIL stream_timeout: got %0d sent want %0d", sent, n); end
  endtask

  task automatic test_stream();
    int f0;
    f0 = fwd_exp;
    out_ready = 1'b0;
    stream(100, 0, 1'b1);
    checks++; if (fwd_count !== 8'(f0 + 100)) begin errors++; $display("FAIL stream_total: got %0d want %0d", fwd_count, f0 + 100); end
  endtask

  task automatic test_saturate();
    stream(250, 10, 1'b0);
    checks++; if (fwd_count !== 8'hFF) begin errors++; $display("FAIL fwd_sat: got %0d want 255", fwd_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_value = mk_msg(4'd1, 4'd1);
    tick();
    in_value = mk_msg(4'd2, 4'd3);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full: got ready=%0h valid=%0h want 0/1", in_ready, out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %0h want 0", out_valid); end
    checks++; if (out_value !== '0) begin errors++; $display("FAIL mid_value_async: got %0h want 0", out_value); end
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0h want 1", in_ready); end
    checks++; if (fwd_count !== 8'd0) begin errors++; $display("FAIL mid_fwd: got %0d want 0", fwd_count); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", drop_count); end
    checks++; if (e_drop_count !== 3'd0) begin errors++; $display("FAIL mid_edge_drop: got %0d want 0", e_drop_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0h want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_offgrid();
    test_link_disabled();
    test_stream();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
